alu_seq: RTL and testbench

Parametrised sequential execute-stage ALU for the RV32I pipeline, extended with iterative RV32M-style multiply and divide. Single-cycle ops (add/sub/logic/compare/shift) return a registered result one cycle after acceptance. Multiply and divide run an XLEN-step iterative datapath. Operands enter and results leave through valid/ready handshakes so the EX stage can stall around long operations; the Z/N/C/V flags are produced alongside each result.

---
 rtl/alu_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with single-cycle ops and iterative mul/div.
// Single-cycle ops register their result one edge after acceptance.
// mul/mulhu use a shift-add loop and div/rem use a restoring loop, one bit
// per cycle plus one finalize cycle, which gives a latency of XLEN+1.
//
// state  | meaning
// S_IDLE | accepting ops; single-cycle results are produced here
// S_MUL  | shift-add steps (counter 0..XLEN-1), then finalize at XLEN
// S_DIV  | restoring steps (counter 0..XLEN-1), then sign fix-up at XLEN
// S_DONE | iterative result valid, waiting for out_ready
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            negative,
  output logic            carry,
  output logic            overflow,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [SHW:0]    CNT_LAST = (SHW+1)'(XLEN);
  localparam logic [SHW:0]    CNT_ONE  = (SHW+1)'(1);
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  state_t              r_state;
  logic [SHW:0]        r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic                r_hi_sel;
  logic                r_rem_sel;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_out_valid;
  logic [XLEN-1:0]     r_result;
  logic                r_zero;
  logic                r_negative;
  logic                r_carry;
  logic                r_overflow;

  logic                w_accept;
  logic                w_is_mul;
  logic                w_is_div;
  logic                w_div_signed;
  logic                w_div_by_zero;
  logic                w_div_ovf;
  logic                w_div_special;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic                w_sub;
  logic [XLEN-1:0]     w_b_add;
  logic [XLEN:0]       w_sum;
  logic [SHW-1:0]      w_shamt;
  logic [XLEN-1:0]     w_res;
  logic                w_c;
  logic                w_v;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [2*XLEN:0]     w_sh;
  logic [XLEN:0]       w_diff;
  logic [2*XLEN-1:0]   w_div_next;
  logic [XLEN-1:0]     w_quo_s;
  logic [XLEN-1:0]     w_rem_s;
  logic [XLEN-1:0]     w_fin;

  assign in_ready  = rst & (r_state == S_IDLE) & (~r_out_valid | out_ready);
  assign w_accept  = in_valid & in_ready;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign carry     = r_carry;
  assign overflow  = r_overflow;

  // Operation class decode and division special cases resolved at accept.
  assign w_is_mul      = (op[3:1] == 3'b101);
  assign w_is_div      = (op[3:2] == 2'b11);
  assign w_div_signed  = w_is_div & ~op[0];
  assign w_div_by_zero = (b == '0);
  assign w_div_ovf     = w_div_signed & (a == MIN_VAL) & (b == '1);
  assign w_div_special = w_is_div & (w_div_by_zero | w_div_ovf);
  assign w_a_mag       = (w_div_signed & a[XLEN-1]) ? -a : a;
  assign w_b_mag       = (w_div_signed & b[XLEN-1]) ? -b : b;

  // Subtraction reuses the adder as a + ~b + 1.
  assign w_sub   = (op == 4'b0001);
  assign w_b_add = w_sub ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_add} + (XLEN+1)'(w_sub);
  assign w_shamt = b[SHW-1:0];

  // Single-cycle result and arithmetic flags.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      4'b0000, 4'b0001: begin
        w_res = w_sum[XLEN-1:0];
        w_c   = w_sum[XLEN];
        w_v   = (a[XLEN-1] == w_b_add[XLEN-1]) & (w_sum[XLEN-1] != a[XLEN-1]);
      end
      4'b0010: w_res = a & b;
      4'b0011: w_res = a | b;
      4'b0100: w_res = a ^ b;
      4'b0101: w_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0110: w_res = {{(XLEN-1){1'b0}}, (a < b)};
      4'b0111: w_res = a << w_shamt;
      4'b1000: w_res = a >> w_shamt;
      4'b1001: w_res = $unsigned($signed(a) >>> w_shamt);
      4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
        if (w_div_by_zero) w_res = op[1] ? a : '1;
        else               w_res = op[1] ? '0 : MIN_VAL;
      end
      default: w_res = '0;
    endcase
  end

  // One shift-add step: add multiplicand into the high half, shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_b[0] ? r_a : '0)};
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // One restoring step: high half is the partial remainder, low half
  // shifts the dividend out and the quotient bits in.
  assign w_sh       = {r_acc, 1'b0};
  assign w_diff     = w_sh[2*XLEN:XLEN] - {1'b0, r_b};
  assign w_div_next = w_diff[XLEN] ? w_sh[2*XLEN-1:0]
                                   : {w_diff[XLEN-1:0], w_sh[XLEN-1:1], 1'b1};

  assign w_quo_s = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem_s = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  // Final value of an iterative op, selected by the running state.
  always_comb begin
    w_fin = '0;
    if (r_state == S_MUL) w_fin = r_hi_sel ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    else                  w_fin = r_rem_sel ? w_rem_s : w_quo_s;
  end

  // Control FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_hi_sel    <= 1'b0;
      r_rem_sel   <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_acc       <= '0;
              r_a         <= a;
              r_b         <= b;
              r_cnt       <= '0;
              r_hi_sel    <= op[0];
              r_out_valid <= 1'b0;
              r_state     <= S_MUL;
            end else if (w_is_div && !w_div_special) begin
              r_acc       <= {{XLEN{1'b0}}, w_a_mag};
              r_b         <= w_b_mag;
              r_cnt       <= '0;
              r_rem_sel   <= op[1];
              r_neg_q     <= w_div_signed & (a[XLEN-1] ^ b[XLEN-1]);
              r_neg_r     <= w_div_signed & a[XLEN-1];
              r_out_valid <= 1'b0;
              r_state     <= S_DIV;
            end else begin
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_negative  <= w_res[XLEN-1];
              r_carry     <= w_c;
              r_overflow  <= w_v;
              r_out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MUL, S_DIV: begin
          if (r_cnt != CNT_LAST) begin
            r_acc <= (r_state == S_MUL) ? w_mul_next : w_div_next;
            if (r_state == S_MUL) r_b <= r_b >> 1;
            r_cnt <= r_cnt + CNT_ONE;
          end else begin
            r_result    <= w_fin;
            r_zero      <= (w_fin == '0);
            r_negative  <= w_fin[XLEN-1];
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (XLEN=32).
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .busy(busy)
  );

  // Present one op for a single edge (caller has checked in_ready).
  task automatic start_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid, noting whether in_ready was ever seen high.
  task automatic wait_out(output int lat, output bit rdy_seen);
    lat = 0; rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b0; op = 4'd0; a = '0; b = '0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if ({zero, negative, carry, overflow} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {zero, negative, carry, overflow}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high: got %b expected 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    op = 4'b0000; a = 32'hFFFF_FFFF; b = 32'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid: got %b expected 1", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL add_result: got %h expected 00000000", result); end
    checks++; if ({zero, negative, carry, overflow} !== 4'b1010) begin errors++; $display("FAIL add_flags: got %b expected 1010", {zero, negative, carry, overflow}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
    op = 4'b0001; a = 32'h8000_0000; b = 32'h1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (result !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_result: got %h expected 7fffffff", result); end
    checks++; if ({zero, negative, carry, overflow} !== 4'b0011) begin errors++; $display("FAIL sub_flags: got %b expected 0011", {zero, negative, carry, overflow}); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_out_valid: got %b expected 1", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_shift_cmp();
    logic [3:0]  t_op[3];
    logic [31:0] t_a[3];
    logic [31:0] t_b[3];
    logic [31:0] t_r[3];
    logic [3:0]  t_f[3];
    t_op = '{4'b1001, 4'b0110, 4'b0101};
    t_a  = '{32'h8000_0000, 32'h1, 32'h1};
    t_b  = '{32'h24, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    t_r  = '{32'hF800_0000, 32'h1, 32'h0};
    t_f  = '{4'b0100, 4'b0000, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      start_op(t_op[i], t_a[i], t_b[i]);
      checks++; if (result !== t_r[i]) begin errors++; $display("FAIL shcmp_result[%0d]: got %h expected %h", i, result, t_r[i]); end
      checks++; if ({zero, negative, carry, overflow} !== t_f[i]) begin errors++; $display("FAIL shcmp_flags[%0d]: got %b expected %b", i, {zero, negative, carry, overflow}, t_f[i]); end
    end
  endtask

  task automatic test_mul();
    int lat; bit rdy;
    start_op(4'b1010, 32'h1234_5678, 32'h10);
    wait_out(lat, rdy);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mul_in_ready_busy: got %b expected 0", rdy); end
    checks++; if (result !== 32'h2345_6780) begin errors++; $display("FAIL mul_result: got %h expected 23456780", result); end
    @(posedge clk); #1;
    start_op(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(lat, rdy);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mulhu_latency: got %0d expected 33", lat); end
    checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_result: got %h expected fffffffe", result); end
    checks++; if ({zero, negative, carry, overflow} !== 4'b0100) begin errors++; $display("FAIL mulhu_flags: got %b expected 0100", {zero, negative, carry, overflow}); end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    int lat; bit rdy;
    start_op(4'b1100, 32'hFFFF_FFF9, 32'h2);
    wait_out(lat, rdy);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end
    checks++; if (result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_result: got %h expected fffffffd", result); end
    @(posedge clk); #1;
    start_op(4'b1110, 32'hFFFF_FFF9, 32'h2);
    wait_out(lat, rdy);
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_result: got %h expected ffffffff", result); end
    checks++; if (negative !== 1'b1) begin errors++; $display("FAIL rem_negative: got %b expected 1", negative); end
    @(posedge clk); #1;
    start_op(4'b1101, 32'h7, 32'h0);
    wait_out(lat, rdy);
    checks++; if (lat !== 0) begin errors++; $display("FAIL divu0_latency: got %0d expected 0", lat); end
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_result: got %h expected ffffffff", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu0_busy: got %b expected 0", busy); end
    start_op(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_out(lat, rdy);
    checks++; if (lat !== 0) begin errors++; $display("FAIL removf_latency: got %0d expected 0", lat); end
    checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL removf_result: got %h z=%b expected 00000000 z=1", result, zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int lat; bit rdy;
    start_op(4'b1010, 32'h3, 32'h5);
    out_ready = 1'b0;
    wait_out(lat, rdy);
    checks++; if (lat !== 33) begin errors++; $display("FAIL stall_latency: got %0d expected 33", lat); end
    op = 4'b0000; a = 32'h1; b = 32'h1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (result !== 32'hF || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %h v=%b expected 0000000f v=1", i, result, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got v=%b busy=%b rdy=%b expected 0 0 1", out_valid, busy, in_ready); end
    checks++; if (result !== 32'hF) begin errors++; $display("FAIL stall_result_kept: got %h expected 0000000f", result); end
  endtask

  task automatic test_reset_mid_div();
    bit seen;
    start_op(4'b1101, 32'd100, 32'd3);
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL middiv_busy: got %b expected 1", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0) begin errors++; $display("FAIL middiv_reset: got busy=%b v=%b r=%h expected 0 0 0", busy, out_valid, result); end
    rst = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL middiv_in_ready: got %b expected 1", in_ready); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL middiv_no_result: got %b expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_shift_cmp();
    test_mul();
    test_div();
    test_stall();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
